// File: rtl/id_hazard_scoreboard.sv
// Shadow scoreboard of the EXE/MEM/WB destinations: drives the ID-stage ready_go,
// the per-operand bypass selects, the stall performance counters and a sticky protocol error.
module id_hazard_scoreboard #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_rs_en_i,
    input  logic             id_rt_en_i,
    input  logic             id_wen_i,
    input  logic [4:0]       id_waddr_i,
    input  logic             id_is_load_i,
    input  logic             id_fire_i,
    input  logic             exe_fire_i,
    input  logic             mem_fire_i,
    input  logic             wb_fire_i,
    output logic             ready_go_o,
    output logic [1:0]       sel_rs_o,
    output logic [1:0]       sel_rt_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] stall_events_o,
    output logic             proto_err_o
);

    typedef struct packed {
        logic       v;
        logic       wen;
        logic [4:0] waddr;
        logic       is_load;
    } entry_t;

    entry_t exe_q, exe_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] stall_events_q, stall_events_d;
    logic             prev_stall_q, prev_stall_d;
    logic             proto_err_q, proto_err_d;
    logic             rs_load_haz, rt_load_haz, stall_now;

    function automatic logic hit(input entry_t e, input logic [4:0] r, input logic en);
        return e.v & e.wen & (e.waddr == r) & (r != 5'd0) & en;
    endfunction

    function automatic logic [1:0] pick(input logic [4:0] r, input logic en,
                                        input entry_t e, input entry_t m, input entry_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (hit(e, r, en))      sel = 2'b01;
        else if (hit(m, r, en)) sel = 2'b10;
        else if (hit(w, r, en)) sel = 2'b11;
        return sel;
    endfunction

    // Only a load sitting in EXE blocks issue; younger-stage loads already have data to forward.
    always_comb begin
        sel_rs_o    = pick(id_rs_i, id_rs_en_i, exe_q, mem_q, wb_q);
        sel_rt_o    = pick(id_rt_i, id_rt_en_i, exe_q, mem_q, wb_q);
        rs_load_haz = hit(exe_q, id_rs_i, id_rs_en_i) & exe_q.is_load;
        rt_load_haz = hit(exe_q, id_rt_i, id_rt_en_i) & exe_q.is_load;
        ready_go_o  = ~(rs_load_haz | rt_load_haz);
        stall_now   = id_valid_i & ~ready_go_o;
    end

    // Each entry reads only the older-cycle value of its upstream neighbour, so simultaneous fires shift cleanly.
    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (id_fire_i)       exe_d = '{v: 1'b1, wen: id_wen_i, waddr: id_waddr_i, is_load: id_is_load_i};
        else if (exe_fire_i) exe_d.v = 1'b0;
        if (exe_fire_i)      mem_d = exe_q;
        else if (mem_fire_i) mem_d.v = 1'b0;
        if (mem_fire_i)      wb_d = mem_q;
        else if (wb_fire_i)  wb_d.v = 1'b0;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        stall_events_d = stall_events_q;
        if (stall_now && stall_cycles_q != {CNT_W{1'b1}})
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (stall_now && !prev_stall_q && stall_events_q != {CNT_W{1'b1}})
            stall_events_d = stall_events_q + CNT_W'(1);
        prev_stall_d = stall_now;
        proto_err_d  = proto_err_q | (id_fire_i & ~ready_go_o);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_q          <= '0;
            mem_q          <= '0;
            wb_q           <= '0;
            stall_cycles_q <= '0;
            stall_events_q <= '0;
            prev_stall_q   <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            exe_q          <= exe_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
            stall_cycles_q <= stall_cycles_d;
            stall_events_q <= stall_events_d;
            prev_stall_q   <= prev_stall_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign stall_events_o = stall_events_q;
    assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: a directed vector table for the pipeline corner cases,
// then random traffic, all checked against a pipeline-slot model of the scoreboard rules.
module tb_id_hazard_scoreboard;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic idValid, rsEn, rtEn, wen, isLoad, idFire, exeFire, memFire, wbFire;
    logic [4:0] rs, rt, waddr;
    logic readyGo, protoErr;
    logic [1:0] selRs, selRt;
    logic [CNT_W-1:0] stallCycles, stallEvents;

    id_hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid_i(idValid), .id_rs_i(rs), .id_rt_i(rt),
        .id_rs_en_i(rsEn), .id_rt_en_i(rtEn),
        .id_wen_i(wen), .id_waddr_i(waddr), .id_is_load_i(isLoad),
        .id_fire_i(idFire), .exe_fire_i(exeFire), .mem_fire_i(memFire), .wb_fire_i(wbFire),
        .ready_go_o(readyGo), .sel_rs_o(selRs), .sel_rt_o(selRt),
        .stall_cycles_o(stallCycles), .stall_events_o(stallEvents), .proto_err_o(protoErr)
    );

    always #5 clk = ~clk;

    // Model: slot 0 = EXE, 1 = MEM, 2 = WB; counters kept as plain integers.
    typedef struct {
        bit       v;
        bit       wen;
        bit [4:0] waddr;
        bit       ld;
    } slot_t;

    slot_t pipe[3];
    int    mCyc, mEvt;
    bit    mPrev, mProto;

    typedef struct {
        logic rst, valid;
        logic [4:0] rs, rt;
        logic rsEn, rtEn, wen;
        logic [4:0] waddr;
        logic ld, idF, exF, meF, wbF;
        logic expReady;
        logic [1:0] expRs, expRt;
        int expCyc, expEvt;
        logic expProto;
    } vec_t;

    vec_t tbl[23];
    int vectors = 0;
    int miscompares = 0;

    function automatic vec_t mkVec(input logic rst, valid, input int vrs, vrt, input logic vrsEn, vrtEn, vwen,
                                   input int vwaddr, input logic ld, idF, exF, meF, wbF,
                                   input logic expReady, input int expRs, expRt, expCyc, expEvt, input logic expProto);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rs = 5'(vrs); v.rt = 5'(vrt);
        v.rsEn = vrsEn; v.rtEn = vrtEn; v.wen = vwen; v.waddr = 5'(vwaddr); v.ld = ld;
        v.idF = idF; v.exF = exF; v.meF = meF; v.wbF = wbF;
        v.expReady = expReady; v.expRs = 2'(expRs); v.expRt = 2'(expRt);
        v.expCyc = expCyc; v.expEvt = expEvt; v.expProto = expProto;
        return v;
    endfunction

    function automatic bit slotHit(input int i, input logic [4:0] r, input logic en);
        return pipe[i].v && pipe[i].wen && pipe[i].waddr == r && r != 0 && en;
    endfunction

    function automatic logic [1:0] modelSel(input logic [4:0] r, input logic en);
        for (int i = 0; i < 3; i++)
            if (slotHit(i, r, en)) return 2'(i + 1);
        return 2'd0;
    endfunction

    function automatic logic modelReady(input vec_t v);
        return !((slotHit(0, v.rs, v.rsEn) || slotHit(0, v.rt, v.rtEn)) && pipe[0].ld);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic modelAdvance(input vec_t v, input logic rdy);
        slot_t oldE, oldM;
        bit stallNow;
        if (v.rst) begin
            foreach (pipe[i]) pipe[i] = '{default: 0};
            mCyc = 0; mEvt = 0; mPrev = 0; mProto = 0;
            return;
        end
        stallNow = v.valid && !rdy;
        if (stallNow && mCyc < CMAX) mCyc++;
        if (stallNow && !mPrev && mEvt < CMAX) mEvt++;
        mPrev = stallNow;
        if (v.idF && !rdy) mProto = 1;
        oldE = pipe[0];
        oldM = pipe[1];
        if (v.meF) pipe[2] = oldM; else if (v.wbF) pipe[2].v = 0;
        if (v.exF) pipe[1] = oldE; else if (v.meF) pipe[1].v = 0;
        if (v.idF) pipe[0] = '{v: 1, wen: v.wen, waddr: v.waddr, ld: v.ld};
        else if (v.exF) pipe[0].v = 0;
    endtask

    // mode 0: drive only, 1: check against model, 2: also check table expectations.
    task automatic applyStimulus(input vec_t v, input int mode, input string tag);
        logic rdy;
        reset = v.rst; idValid = v.valid; rs = v.rs; rt = v.rt; rsEn = v.rsEn; rtEn = v.rtEn;
        wen = v.wen; waddr = v.waddr; isLoad = v.ld;
        idFire = v.idF; exeFire = v.exF; memFire = v.meF; wbFire = v.wbF;
        #4;
        rdy = modelReady(v);
        if (mode >= 1) begin
            checkOutput({tag, " ready_go"}, int'(readyGo), int'(rdy));
            checkOutput({tag, " sel_rs"}, int'(selRs), int'(modelSel(v.rs, v.rsEn)));
            checkOutput({tag, " sel_rt"}, int'(selRt), int'(modelSel(v.rt, v.rtEn)));
            checkOutput({tag, " stall_cycles"}, int'(stallCycles), mCyc);
            checkOutput({tag, " stall_events"}, int'(stallEvents), mEvt);
            checkOutput({tag, " proto_err"}, int'(protoErr), int'(mProto));
        end
        if (mode == 2) begin
            checkOutput({tag, " tbl ready_go"}, int'(readyGo), int'(v.expReady));
            checkOutput({tag, " tbl sel_rs"}, int'(selRs), int'(v.expRs));
            checkOutput({tag, " tbl sel_rt"}, int'(selRt), int'(v.expRt));
            checkOutput({tag, " tbl stall_cycles"}, int'(stallCycles), v.expCyc);
            checkOutput({tag, " tbl stall_events"}, int'(stallEvents), v.expEvt);
            checkOutput({tag, " tbl proto_err"}, int'(protoErr), int'(v.expProto));
        end
        @(posedge clk);
        modelAdvance(v, rdy);
        #1;
    endtask

    initial begin
        vec_t v;
        //                 rst val rs rt rsE rtE wen wa ld idF exF meF wbF | rdy sRs sRt cyc evt pe
        tbl[0]  = mkVec(0, 1, 1, 2, 1, 1, 1, 3, 0, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0);
        tbl[1]  = mkVec(0, 1, 5, 6, 1, 1, 1, 4, 0, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0);
        tbl[2]  = mkVec(0, 1, 4, 3, 1, 1, 1, 9, 0, 1, 1, 1, 1,  1, 1, 2, 0, 0, 0);
        tbl[3]  = mkVec(0, 1, 3, 4, 1, 1, 0, 0, 0, 1, 1, 1, 1,  1, 3, 2, 0, 0, 0);
        tbl[4]  = mkVec(0, 1, 9, 0, 1, 1, 1, 9, 0, 1, 1, 1, 1,  1, 2, 0, 0, 0, 0);
        tbl[5]  = mkVec(0, 1, 9, 0, 1, 1, 1, 9, 0, 1, 1, 1, 1,  1, 1, 0, 0, 0, 0);
        tbl[6]  = mkVec(0, 1, 9, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 0);
        tbl[7]  = mkVec(0, 1, 9, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0);
        tbl[8]  = mkVec(0, 1, 9, 0, 0, 0, 1, 8, 1, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0);
        tbl[9]  = mkVec(0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 1, 1, 1,  0, 0, 1, 0, 0, 0);
        tbl[10] = mkVec(0, 1, 0, 8, 1, 1, 0, 0, 0, 1, 1, 1, 1,  1, 0, 2, 1, 1, 0);
        tbl[11] = mkVec(0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1,  1, 0, 0, 1, 1, 0);
        tbl[12] = mkVec(0, 1, 0, 0, 1, 1, 1, 7, 1, 1, 1, 1, 1,  1, 0, 0, 1, 1, 0);
        tbl[13] = mkVec(0, 1, 0, 7, 1, 0, 1, 7, 1, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0);
        tbl[14] = mkVec(0, 1, 0, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0);
        tbl[15] = mkVec(0, 1, 0, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 2, 2, 0);
        tbl[16] = mkVec(0, 1, 0, 7, 1, 1, 1, 7, 1, 1, 0, 0, 0,  0, 0, 1, 3, 2, 0);
        tbl[17] = mkVec(0, 1, 0, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 4, 2, 1);
        tbl[18] = mkVec(0, 1, 0, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 5, 2, 1);
        tbl[19] = mkVec(0, 0, 0, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 6, 2, 1);
        tbl[20] = mkVec(0, 1, 0, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 6, 2, 1);
        tbl[21] = mkVec(1, 1, 0, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0,  0, 0, 1, 7, 3, 1);
        tbl[22] = mkVec(0, 1, 0, 7, 1, 1, 1, 7, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);

        v = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        applyStimulus(v, 0, "reset");
        applyStimulus(v, 0, "reset");

        for (int i = 0; i < 23; i++)
            applyStimulus(tbl[i], 2, $sformatf("row%0d", i));

        for (int n = 0; n < 600; n++) begin
            v = mkVec(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                      ($urandom_range(0, 3) != 0), $urandom_range(0, 3), ($urandom_range(0, 1) == 1),
                      0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                      0, 0, 0, 0, 0, 0);
            v.idF = modelReady(v) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0);
            applyStimulus(v, 1, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
